// File: rtl/cpu_memory_stage.sv
// cpu_memory_stage: memory pipeline stage between execute and writeback; performs load/store/flush on the data bus.
// Ports: i_clock, i_reset_n (sync, active-low); i_data execute record in, o_data writeback record out (registered);
//   o_bus_* / i_bus_rdata / i_bus_ready data bus; o_busy stall to upstream; o_raw load-use hazard against
//   i_rs1_index / i_rs2_index; o_fault sticky fault on bad width (or misalignment).
// Build option: define CPU_MEMORY_MISALIGN_FAULT_EN to fault on misaligned half/word accesses instead of
//   forcing them aligned.
package cpu_memory_pkg;
  typedef struct packed {
    logic [3:0]  tag;
    logic [4:0]  inst_rd;
    logic [31:0] rd;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic        mem_flush;
    logic [2:0]  mem_width;
    logic        mem_signed;
  } execute_data_t;
  typedef struct packed {
    logic [3:0]  tag;
    logic [4:0]  inst_rd;
    logic [31:0] rd;
  } memory_data_t;
endpackage

module cpu_memory_stage
  import cpu_memory_pkg::*;
(
  input  logic          i_clock,
  input  logic          i_reset_n,
  output logic          o_fault,
  output logic          o_busy,
  output logic          o_raw,
  input  logic [4:0]    i_rs1_index,
  input  logic [4:0]    i_rs2_index,
  input  execute_data_t i_data,
  output logic          o_bus_request,
  output logic          o_bus_rw,
  output logic          o_bus_flush,
  output logic [31:0]   o_bus_address,
  output logic [3:0]    o_bus_wmask,
  output logic [31:0]   o_bus_wdata,
  input  logic [31:0]   i_bus_rdata,
  input  logic          i_bus_ready,
  output memory_data_t  o_data
);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state_q, state_d;
  logic fault_q, fault_d, req_q, req_d, rw_q, rw_d, flush_q, flush_d, read_q, read_d, sign_q, sign_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0] wmask_q, wmask_d, tag_q, tag_d;
  logic [2:0] width_q, width_d, w;
  logic [1:0] off_q, off_d, a, off;
  logic [4:0] dst_q, dst_d;
  memory_data_t data_q, data_d;
  logic is_mem, accept, bad;
  logic [31:0] v, load_val;

  assign w = i_data.mem_width;
  assign a = i_data.mem_address[1:0];
  assign is_mem = i_data.mem_read | i_data.mem_write | i_data.mem_flush;
  assign accept = (i_data.tag != data_q.tag) && state_q == IDLE && !fault_q;
`ifdef CPU_MEMORY_MISALIGN_FAULT_EN
  assign bad = !(w == 3'd1 || w == 3'd2 || w == 3'd4) || (w == 3'd2 && a[0]) || (w == 3'd4 && a != 2'd0);
  assign off = a;
`else
  assign bad = !(w == 3'd1 || w == 3'd2 || w == 3'd4);
  // misaligned halves/words are silently snapped to their natural boundary
  assign off = w == 3'd4 ? 2'd0 : w == 3'd2 ? {a[1], 1'b0} : a;
`endif
  // load data is shifted down to the addressed byte lane before extension
  assign v = i_bus_rdata >> {off_q, 3'b000};
  assign load_val = width_q == 3'd1 ? {{24{sign_q & v[7]}}, v[7:0]}
                  : width_q == 3'd2 ? {{16{sign_q & v[15]}}, v[15:0]} : v;

  assign o_fault       = fault_q;
  assign o_busy        = state_q == ACCESS || fault_q || ((i_data.tag != data_q.tag) && is_mem);
  assign o_raw         = state_q == ACCESS && read_q && dst_q != 5'd0 && (dst_q == i_rs1_index || dst_q == i_rs2_index);
  assign o_bus_request = req_q;
  assign o_bus_rw      = rw_q;
  assign o_bus_flush   = flush_q;
  assign o_bus_address = addr_q;
  assign o_bus_wmask   = wmask_q;
  assign o_bus_wdata   = wdata_q;
  assign o_data        = data_q;

  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    req_d = req_q;
    rw_d = rw_q;
    flush_d = flush_q;
    read_d = read_q;
    sign_d = sign_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    tag_d = tag_q;
    width_d = width_q;
    off_d = off_q;
    dst_d = dst_q;
    data_d = data_q;
    if (accept) begin
      if (!is_mem) data_d = {i_data.tag, i_data.inst_rd, i_data.rd};
      else if (bad) fault_d = 1'b1;
      else begin
        state_d = ACCESS;
        req_d = 1'b1;
        flush_d = i_data.mem_flush;
        read_d = !i_data.mem_flush && i_data.mem_read;
        rw_d = !i_data.mem_flush && !i_data.mem_read && i_data.mem_write;
        addr_d = {i_data.mem_address[31:2], 2'b00};
        wmask_d = !rw_d ? 4'b0000 : w == 3'd1 ? 4'b0001 << off : w == 3'd2 ? 4'b0011 << off : 4'b1111;
        wdata_d = w == 3'd1 ? {4{i_data.rd[7:0]}} : w == 3'd2 ? {2{i_data.rd[15:0]}} : i_data.rd;
        sign_d = i_data.mem_signed;
        width_d = w;
        off_d = off;
        dst_d = i_data.inst_rd;
        tag_d = i_data.tag;
      end
    end else if (state_q == ACCESS && i_bus_ready) begin
      state_d = IDLE;
      req_d = 1'b0;
      data_d = {tag_q, read_q ? dst_q : 5'd0, read_q ? load_val : 32'd0};
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      fault_q <= 1'b0;
      req_q <= 1'b0;
      rw_q <= 1'b0;
      flush_q <= 1'b0;
      read_q <= 1'b0;
      sign_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      tag_q <= '0;
      width_q <= '0;
      off_q <= '0;
      dst_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      req_q <= req_d;
      rw_q <= rw_d;
      flush_q <= flush_d;
      read_q <= read_d;
      sign_q <= sign_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      tag_q <= tag_d;
      width_q <= width_d;
      off_q <= off_d;
      dst_q <= dst_d;
      data_q <= data_d;
    end
  end
endmodule

// File: tb/tb_cpu_memory_stage.sv
// tb_cpu_memory_stage: scoreboard bench for cpu_memory_stage against a byte-addressed memory model.
module tb_cpu_memory_stage;
  import cpu_memory_pkg::*;
  typedef struct packed {
    logic        rw;
    logic        fl;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
  } bus_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  execute_data_t din;
  memory_data_t dout;
  logic fault, busy, raw, req, rw, fl, ready;
  logic [4:0] rs1, rs2;
  logic [31:0] baddr, wdata, rdata;
  logic [3:0] wmask;

  int vectors = 0;
  int miscompares = 0;
  int force_wait = -1;
  bit sb_en = 1'b0;
  logic [3:0] cur_tag = 4'd0;
  memory_data_t dq[$];
  bus_t bq[$];
  logic [7:0] mmem[int];
  logic [31:0] bmem[int];

  cpu_memory_stage dut (
    .i_clock(clk), .i_reset_n(rst_n), .o_fault(fault), .o_busy(busy), .o_raw(raw),
    .i_rs1_index(rs1), .i_rs2_index(rs2), .i_data(din),
    .o_bus_request(req), .o_bus_rw(rw), .o_bus_flush(fl), .o_bus_address(baddr),
    .o_bus_wmask(wmask), .o_bus_wdata(wdata), .i_bus_rdata(rdata), .i_bus_ready(ready),
    .o_data(dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input string what);
    vectors++;
    miscompares++;
    $display("FAIL %s: %s", name, what);
  endtask

  function automatic logic [31:0] hw(input int i);
    return (i * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic logic [31:0] bword(input int i);
    return bmem.exists(i) ? bmem[i] : hw(i);
  endfunction

  function automatic logic [7:0] mbyte(input int ad);
    logic [31:0] h;
    h = hw(ad / 4);
    return mmem.exists(ad) ? mmem[ad] : h[8*(ad%4) +: 8];
  endfunction

  task automatic preload(input int ad, input logic [31:0] val);
    bmem[ad / 4] = val;
    for (int k = 0; k < 4; k++) mmem[ad + k] = val[8*k +: 8];
  endtask

  // issue one instruction, push its expected result/bus transaction, wait for o_data to take its tag
  task automatic issue(input logic ff, input logic fr, input logic fw, input logic [31:0] addr, input int w,
                       input logic sg, input logic [31:0] d, input logic [4:0] idx, output int bc, output int lat);
    memory_data_t e;
    bus_t b;
    logic [31:0] v;
    logic [3:0] t;
    int ea;
    bit ld, raw_exp;
    t = cur_tag + 4'd1;
    ld = fr && !ff;
    ea = int'(addr) & ~(w - 1);
    v = 32'd0;
    if (ff || fr || fw) begin
      b.rw = !ff && !fr;
      b.fl = ff;
      b.addr = 32'(ea) & ~32'd3;
      b.mask = 4'd0;
      b.wdata = w == 1 ? {4{d[7:0]}} : w == 2 ? {2{d[15:0]}} : d;
      for (int k = 0; k < w; k++) begin
        if (b.rw) begin
          b.mask[(ea + k) % 4] = 1'b1;
          mmem[ea + k] = d[8*k +: 8];
        end
        if (ld) v[8*k +: 8] = mbyte(ea + k);
      end
      if (ld && sg && v[8*w-1]) for (int k = w; k < 4; k++) v[8*k +: 8] = 8'hFF;
      bq.push_back(b);
      e = {t, ld ? idx : 5'd0, v};
    end else e = {t, idx, d};
    dq.push_back(e);
    raw_exp = ld && idx != 5'd0 && (idx == rs1 || idx == rs2);
    din = '0;
    din.tag = t;
    din.inst_rd = idx;
    din.rd = d;
    din.mem_address = addr;
    din.mem_read = fr;
    din.mem_write = fw;
    din.mem_flush = ff;
    din.mem_width = 3'(w);
    din.mem_signed = sg;
    bc = 0;
    lat = 0;
    #1;
    chk("raw_idle", {95'd0, raw}, 96'd0);
    if (busy) bc++;
    while (dout.tag != t && lat < 40) begin
      @(negedge clk);
      lat++;
      if (dout.tag != t) begin
        if (busy) bc++;
        chk("raw_access", {95'd0, raw}, {95'd0, raw_exp});
      end
    end
    if (dout.tag != t) flag("timeout", "o_data tag never updated within 40 cycles");
    cur_tag = t;
  endtask

  // bus slave: word memory updated only from what the DUT drives onto the bus
  initial begin
    int cnt, wt, lim, i;
    bit done;
    logic [31:0] word;
    cnt = 0;
    wt = 0;
    done = 1'b0;
    ready = 1'b0;
    rdata = 32'd0;
    forever begin
      @(negedge clk);
      lim = force_wait >= 0 ? force_wait : wt;
      if (req && !done) begin
        if (cnt >= lim) begin
          i = int'(baddr >> 2);
          word = bword(i);
          if (rw) begin
            for (int k = 0; k < 4; k++) if (wmask[k]) word[8*k +: 8] = wdata[8*k +: 8];
            bmem[i] = word;
          end
          rdata = fl ? $urandom : word;
          ready = 1'b1;
          done = 1'b1;
        end else begin
          ready = 1'b0;
          cnt++;
        end
      end else begin
        done = 1'b0;
        cnt = 0;
        wt = $urandom_range(0, 3);
        ready = !req && ($urandom_range(0, 4) == 0);
        rdata = $urandom;
      end
    end
  end

  // monitor: pops expectations whenever o_data changes or a bus request rises
  initial begin
    memory_data_t prev_d, e;
    logic prev_req;
    bus_t cap, eb, now;
    prev_d = '0;
    prev_req = 1'b0;
    cap = '0;
    forever begin
      @(negedge clk);
      now = {rw, fl, baddr, wmask, wdata};
      if (sb_en && dout !== prev_d) begin
        if (dq.size() == 0) flag("o_data", "output changed with no instruction outstanding");
        else begin
          e = dq.pop_front();
          chk("o_data", 96'(dout), 96'(e));
        end
      end
      if (sb_en && req && !prev_req) begin
        if (bq.size() == 0) flag("bus_request", "request raised with no memory op outstanding");
        else begin
          eb = bq.pop_front();
          chk("bus_addr", 96'(baddr), 96'(eb.addr));
          chk("bus_rw", 96'(rw), 96'(eb.rw));
          chk("bus_flush", 96'(fl), 96'(eb.fl));
          if (eb.rw) begin
            chk("bus_wmask", 96'(wmask), 96'(eb.mask));
            chk("bus_wdata", 96'(wdata), 96'(eb.wdata));
          end
        end
      end else if (sb_en && req && prev_req) chk("bus_hold", 96'(now), 96'(cap));
      if (req && !prev_req) cap = now;
      prev_d = dout;
      prev_req = req;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int bc, lat, w;
    logic [31:0] a;
    logic [2:0] f;
    din = '0;
    rs1 = 5'd0;
    rs2 = 5'd0;
    repeat (3) @(negedge clk);
    chk("rst_fault", 96'(fault), 96'd0);
    chk("rst_busy", 96'(busy), 96'd0);
    chk("rst_raw", 96'(raw), 96'd0);
    chk("rst_req", 96'(req), 96'd0);
    chk("rst_rw", 96'(rw), 96'd0);
    chk("rst_flush", 96'(fl), 96'd0);
    chk("rst_addr", 96'(baddr), 96'd0);
    chk("rst_wmask", 96'(wmask), 96'd0);
    chk("rst_wdata", 96'(wdata), 96'd0);
    chk("rst_odata", 96'(dout), 96'd0);
    rst_n = 1'b1;
    sb_en = 1'b1;
    @(negedge clk);
    issue(0, 0, 0, 32'h0, 4, 0, 32'h1234, 5'd3, bc, lat);
    chk("alu_latency", 96'(lat), 96'd1);
    chk("alu_busy", 96'(bc), 96'd0);
    preload(32'h100, 32'hAB000000);
    force_wait = 2;
    rs1 = 5'd0;
    rs2 = 5'd5;
    issue(0, 1, 0, 32'h103, 1, 1, 32'h0, 5'd5, bc, lat);
    chk("lb_busy_cycles", 96'(bc), 96'd4);
    chk("lb_latency", 96'(lat), 96'd4);
    chk("raw_after_ready", 96'(raw), 96'd0);
    force_wait = 0;
    issue(0, 1, 0, 32'h102, 2, 0, 32'h0, 5'd0, bc, lat);
    chk("lhu_zero_wait_latency", 96'(lat), 96'd2);
    force_wait = -1;
    issue(0, 0, 1, 32'h206, 2, 0, 32'h0000CAFE, 5'd9, bc, lat);
`ifndef CPU_MEMORY_MISALIGN_FAULT_EN
    issue(0, 1, 0, 32'h301, 4, 0, 32'h0, 5'd7, bc, lat);
`endif
    issue(1, 1, 1, 32'h120, 4, 0, 32'h5555AAAA, 5'd4, bc, lat);
    issue(0, 1, 1, 32'h206, 2, 1, 32'h0, 5'd6, bc, lat);
    for (int n = 0; n < 150; n++) begin
      f = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom);
      w = 1 << $urandom_range(0, 2);
      a = 32'h100 + 32'($urandom_range(0, 63));
`ifdef CPU_MEMORY_MISALIGN_FAULT_EN
      a = a & ~32'(w - 1);
`endif
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      issue(f[2], f[1], f[0], a, w, 1'($urandom), $urandom, 5'($urandom_range(0, 7)), bc, lat);
    end
    @(negedge clk);
`ifdef CPU_MEMORY_MISALIGN_FAULT_EN
    a = 32'h301;
    w = 4;
`else
    a = 32'h100;
    w = 3;
`endif
    din = '0;
    din.tag = cur_tag + 4'd1;
    din.mem_read = 1'b1;
    din.mem_address = a;
    din.mem_width = 3'(w);
    din.inst_rd = 5'd6;
    @(negedge clk);
    chk("fault_set", 96'(fault), 96'd1);
    chk("fault_busy", 96'(busy), 96'd1);
    chk("fault_no_req", 96'(req), 96'd0);
    chk("fault_tag_held", 96'(dout.tag), 96'(cur_tag));
    din.mem_read = 1'b0;
    din.mem_width = 3'd4;
    repeat (2) @(negedge clk);
    chk("fault_sticky", 96'(fault), 96'd1);
    chk("fault_busy_hold", 96'(busy), 96'd1);
    chk("fault_tag_stuck", 96'(dout.tag), 96'(cur_tag));
    chk("fault_still_no_req", 96'(req), 96'd0);
    sb_en = 1'b0;
    din = '0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("fault_cleared", 96'(fault), 96'd0);
    rst_n = 1'b1;
    cur_tag = 4'd0;
    @(negedge clk);
    chk("post_fault_busy", 96'(busy), 96'd0);
    force_wait = 30;
    din.tag = cur_tag + 4'd1;
    din.mem_read = 1'b1;
    din.mem_width = 3'd4;
    din.mem_address = 32'h110;
    din.inst_rd = 5'd3;
    repeat (3) @(negedge clk);
    chk("access_req", 96'(req), 96'd1);
    rst_n = 1'b0;
    din = '0;
    @(negedge clk);
    chk("rst_mid_req_drop", 96'(req), 96'd0);
    chk("rst_mid_odata", 96'(dout), 96'd0);
    rst_n = 1'b1;
    force_wait = 0;
    repeat (3) @(negedge clk);
    chk("late_ready_odata", 96'(dout), 96'd0);
    chk("late_ready_req", 96'(req), 96'd0);
    force_wait = -1;
    sb_en = 1'b1;
    issue(0, 0, 0, 32'h0, 4, 0, 32'h0BADF00D, 5'd2, bc, lat);
    issue(0, 1, 0, 32'h104, 4, 0, 32'h0, 5'd8, bc, lat);
    @(negedge clk);
    chk("dq_drained", 96'(dq.size()), 96'd0);
    chk("bq_drained", 96'(bq.size()), 96'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
